// File: rtl/code6_pkg.sv
// Package for the 6-bit code serial transmitter.
// Holds the code table constants, the FSM state type and the legal-symbol check
// shared by the encoder LUT and the transmitter top.
package code6_pkg;

    localparam logic [5:0] CODE_111 = 6'b101010;
    localparam logic [5:0] CODE_010 = 6'b101100;
    localparam logic [5:0] CODE_110 = 6'b101101;
    localparam logic [5:0] CODE_011 = 6'b011011;
    localparam logic [5:0] CODE_001 = 6'b101111;
    localparam logic [5:0] CODE_000 = 6'b000000;

    localparam int CODE_BITS = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    // Symbols 100 and 101 have no code word.
    function automatic logic legal_sym(input logic [2:0] sym);
        return !((sym == 3'b100) || (sym == 3'b101));
    endfunction

endpackage

// File: rtl/code6_serial_tx_if.sv
// Symbol/serial bundle of the 6-bit code transmitter.
//   sym_in/sym_valid/sym_ready : symbol handshake from the producer
//   tx_out/tx_frame            : serial pin and frame qualifier
//   code_out/code_stb          : last legal code word and its update strobe
//   err/err_cnt                : illegal-symbol pulse and saturating count
// master = producer / observer side, slave = transmitter.
interface code6_serial_tx_if #(
    parameter int ERR_W = 8
) ();

    logic [2:0]       sym_in;
    logic             sym_valid;
    logic             sym_ready;
    logic             tx_out;
    logic             tx_frame;
    logic [5:0]       code_out;
    logic             code_stb;
    logic             err;
    logic [ERR_W-1:0] err_cnt;

    modport master (
        output sym_in,
        output sym_valid,
        input  sym_ready,
        input  tx_out,
        input  tx_frame,
        input  code_out,
        input  code_stb,
        input  err,
        input  err_cnt
    );

    modport slave (
        input  sym_in,
        input  sym_valid,
        output sym_ready,
        output tx_out,
        output tx_frame,
        output code_out,
        output code_stb,
        output err,
        output err_cnt
    );

endinterface

// File: rtl/code6_encode_lut.sv
// Combinational 3-bit symbol to 6-bit code word map.
// Ports:
//   i_sym   in  3  symbol
//   o_code  out 6  code word (zero for illegal symbols)
//   o_legal out 1  symbol has a code word
module code6_encode_lut
    import code6_pkg::*;
(
    input  logic [2:0] i_sym,
    output logic [5:0] o_code,
    output logic       o_legal
);

    always_comb begin
        o_code  = '0;
        o_legal = legal_sym(i_sym);
        case (i_sym)
            3'b111:  o_code = CODE_111;
            3'b010:  o_code = CODE_010;
            3'b110:  o_code = CODE_110;
            3'b011:  o_code = CODE_011;
            3'b001:  o_code = CODE_001;
            3'b000:  o_code = CODE_000;
            default: o_code = '0;
        endcase
    end

endmodule

// File: rtl/code6_serial_tx.sv
// Transmit side of the 6-bit code link. Accepts a 3-bit symbol on a
// valid/ready handshake, encodes it and shifts the code word out MSB first,
// each bit held BIT_CYCLES clocks, followed by GAP_CYCLES idle clocks.
// Ports:
//   clk  in  1  clock, rising edge
//   rst  in  1  synchronous active-high reset
//   bus  slave modport of code6_serial_tx_if (handshake, serial pin,
//        code_out/code_stb, err/err_cnt)
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | sym_ready high, waiting for a symbol; illegal symbols are
//       | counted here without leaving IDLE
// SHIFT | code bit on tx_out, tx_frame high
// GAP   | inter-frame idle, tx_out at IDLE_LVL, not ready
module code6_serial_tx
    import code6_pkg::*;
#(
    parameter int   BIT_CYCLES = 4,
    parameter int   GAP_CYCLES = 2,
    parameter logic IDLE_LVL   = 1'b0,
    parameter int   ERR_W      = 8
) (
    input logic              clk,
    input logic              rst,
    code6_serial_tx_if.slave bus
);

    localparam int DIV_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BIT_CYCLES - 1);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam bit               HAS_GAP  = (GAP_CYCLES > 0);

    state_t           r_state;
    state_t           w_state_nxt;

    // Bits still to send after the one currently on tx_out.
    logic [4:0]       r_shreg;
    logic [2:0]       r_bit_cnt;
    logic [DIV_W-1:0] r_div_cnt;
    logic [GAP_W-1:0] r_gap_cnt;
    logic             r_tx_out;
    logic             r_tx_frame;
    logic [5:0]       r_code_out;
    logic             r_code_stb;
    logic             r_err;
    logic [ERR_W-1:0] r_err_cnt;

    logic [5:0]       w_code;
    logic             w_legal;
    logic             w_sym_ready;
    logic             w_accept;
    logic             w_div_wrap;
    logic             w_last_bit;
    logic             w_gap_done;

    code6_encode_lut u_lut (
        .i_sym   (bus.sym_in),
        .o_code  (w_code),
        .o_legal (w_legal)
    );

    assign w_sym_ready = (r_state == IDLE);
    assign w_accept    = bus.sym_valid && w_sym_ready;
    assign w_div_wrap  = (r_div_cnt == DIV_LAST);
    assign w_last_bit  = w_div_wrap && (r_bit_cnt == 3'(CODE_BITS - 1));
    assign w_gap_done  = (r_gap_cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept && w_legal) begin
                    w_state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (w_last_bit) begin
                    w_state_nxt = HAS_GAP ? GAP : IDLE;
                end
            end
            GAP: begin
                if (w_gap_done) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shreg    <= '0;
            r_bit_cnt  <= '0;
            r_div_cnt  <= '0;
            r_gap_cnt  <= '0;
            r_tx_out   <= IDLE_LVL;
            r_tx_frame <= 1'b0;
            r_code_out <= '0;
            r_code_stb <= 1'b0;
            r_err      <= 1'b0;
            r_err_cnt  <= '0;
        end else begin
            r_code_stb <= 1'b0;
            r_err      <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        if (w_legal) begin
                            // Bit 5 goes straight to the output register so it
                            // appears on the cycle after the accept edge.
                            r_shreg    <= w_code[4:0];
                            r_code_out <= w_code;
                            r_code_stb <= 1'b1;
                            r_bit_cnt  <= '0;
                            r_div_cnt  <= '0;
                            r_tx_out   <= w_code[5];
                            r_tx_frame <= 1'b1;
                        end else begin
                            r_err <= 1'b1;
                            if (r_err_cnt != '1) begin
                                r_err_cnt <= r_err_cnt + 1'b1;
                            end
                        end
                    end
                end
                SHIFT: begin
                    if (w_div_wrap) begin
                        r_div_cnt <= '0;
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                        r_shreg   <= {r_shreg[3:0], 1'b0};
                        if (w_last_bit) begin
                            r_tx_out   <= IDLE_LVL;
                            r_tx_frame <= 1'b0;
                            r_gap_cnt  <= GAP_LOAD;
                        end else begin
                            r_tx_out <= r_shreg[4];
                        end
                    end else begin
                        r_div_cnt <= r_div_cnt + 1'b1;
                    end
                end
                GAP: begin
                    if (!w_gap_done) begin
                        r_gap_cnt <= r_gap_cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.sym_ready = w_sym_ready;
    assign bus.tx_out    = r_tx_out;
    assign bus.tx_frame  = r_tx_frame;
    assign bus.code_out  = r_code_out;
    assign bus.code_stb  = r_code_stb;
    assign bus.err       = r_err;
    assign bus.err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_code6_serial_tx.sv
module tb_code6_serial_tx;

    localparam int   BIT_CYCLES = 4;
    localparam int   GAP_CYCLES = 2;
    localparam logic IDLE_LVL   = 1'b0;
    localparam int   ERR_W      = 8;
    localparam int   FRAME_LEN  = 6 * BIT_CYCLES;
    localparam int   ERR_MAX    = (1 << ERR_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    code6_serial_tx_if #(.ERR_W(ERR_W)) bus ();

    code6_serial_tx #(
        .BIT_CYCLES (BIT_CYCLES),
        .GAP_CYCLES (GAP_CYCLES),
        .IDLE_LVL   (IDLE_LVL),
        .ERR_W      (ERR_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_total = 0;
    int n_pass  = 0;

    logic [5:0]  ref_code [8];
    bit          ref_legal [8];
    int unsigned exp_err_cnt  = 0;
    logic [5:0]  exp_code_out = '0;
    logic        cap_bits [$];
    bit          cap_timeout;

    function automatic int unsigned sat_add(input int unsigned a, input int unsigned b);
        int unsigned r = a + b;
        return (r > ERR_MAX) ? ERR_MAX : r;
    endfunction

    function automatic int sample_errs(input logic [5:0] code);
        int errs = 0;
        for (int i = 0; i < cap_bits.size(); i++) begin
            if (i >= FRAME_LEN) errs++;
            else if (cap_bits[i] !== code[5 - i / BIT_CYCLES]) errs++;
        end
        return errs;
    endfunction

    // Receiver model: sample mid-bit, then look the word up in the code table.
    function automatic logic [5:0] word_from_samples();
        logic [5:0] w = '0;
        for (int b = 0; b < 6; b++) begin
            int idx = b * BIT_CYCLES + BIT_CYCLES / 2;
            if (idx < cap_bits.size()) w[5 - b] = cap_bits[idx];
        end
        return w;
    endfunction

    function automatic logic [3:0] decode_word(input logic [5:0] w);
        // {found, sym}
        for (int s = 0; s < 8; s++) begin
            if (ref_legal[s] && ref_code[s] === w) return {1'b1, 3'(s)};
        end
        return 4'b0000;
    endfunction

    task automatic drive_sym(input logic [2:0] s, output bit ok);
        int w = 0;
        bus.sym_in    = s;
        bus.sym_valid = 1'b1;
        while (bus.sym_ready !== 1'b1 && w < 200) begin
            @(negedge clk);
            w++;
        end
        ok = (w < 200);
        @(negedge clk);
        bus.sym_valid = 1'b0;
    endtask

    task automatic capture_frame();
        int w = 0;
        cap_bits.delete();
        cap_timeout = 1'b0;
        while (bus.tx_frame !== 1'b1 && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (w >= 100) begin
            cap_timeout = 1'b1;
            return;
        end
        w = 0;
        while (bus.tx_frame === 1'b1 && w < 4 * FRAME_LEN) begin
            cap_bits.push_back(bus.tx_out);
            @(negedge clk);
            w++;
        end
        if (w >= 4 * FRAME_LEN) cap_timeout = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.sym_valid = 1'b0;
        bus.sym_in    = 3'b000;
        repeat (3) @(negedge clk);
        n_total++; if (bus.sym_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", bus.sym_ready); else n_pass++;
        n_total++; if (bus.tx_out !== IDLE_LVL) $display("FAIL reset_tx_out: got %b want %b", bus.tx_out, IDLE_LVL); else n_pass++;
        n_total++; if (bus.tx_frame !== 1'b0) $display("FAIL reset_tx_frame: got %b want 0", bus.tx_frame); else n_pass++;
        n_total++; if (bus.code_out !== 6'b0) $display("FAIL reset_code_out: got %b want 000000", bus.code_out); else n_pass++;
        n_total++; if (bus.code_stb !== 1'b0 || bus.err !== 1'b0) $display("FAIL reset_pulses: got stb=%b err=%b want 0 0", bus.code_stb, bus.err); else n_pass++;
        n_total++; if (bus.err_cnt !== ERR_W'(0)) $display("FAIL reset_err_cnt: got %0d want 0", bus.err_cnt); else n_pass++;
        rst = 1'b0;
        @(negedge clk);
        n_total++; if (bus.sym_ready !== 1'b1) $display("FAIL post_reset_ready: got %b want 1", bus.sym_ready); else n_pass++;
        exp_err_cnt  = 0;
        exp_code_out = '0;
    endtask

    task automatic test_single_111();
        bit ok;
        drive_sym(3'b111, ok);
        n_total++; if (!ok) $display("FAIL single_accept: timed out waiting for sym_ready"); else n_pass++;
        n_total++; if (bus.code_stb !== 1'b1) $display("FAIL single_code_stb: got %b want 1", bus.code_stb); else n_pass++;
        n_total++; if (bus.code_out !== ref_code[7]) $display("FAIL single_code_out: got %b want %b", bus.code_out, ref_code[7]); else n_pass++;
        exp_code_out = ref_code[7];
        capture_frame();
        n_total++; if (cap_timeout) $display("FAIL single_capture: frame timeout"); else n_pass++;
        n_total++; if (cap_bits.size() !== FRAME_LEN) $display("FAIL single_frame_len: got %0d want %0d", cap_bits.size(), FRAME_LEN); else n_pass++;
        n_total++; if (sample_errs(ref_code[7]) !== 0) $display("FAIL single_bits: got %0d bad samples want 0", sample_errs(ref_code[7])); else n_pass++;
        n_total++; if (bus.tx_out !== IDLE_LVL) $display("FAIL single_idle_after: got %b want %b", bus.tx_out, IDLE_LVL); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int w = 0;
        int errs = 0, rdy_errs = 0, stb = 0;
        int total_len = 2 * FRAME_LEN + GAP_CYCLES + 1;
        int f2 = FRAME_LEN + GAP_CYCLES + 1;
        logic [5:0] ca, cb;
        ca = ref_code[2];
        cb = ref_code[3];
        bus.sym_in    = 3'b010;
        bus.sym_valid = 1'b1;
        while (bus.sym_ready !== 1'b1 && w < 200) begin
            @(negedge clk);
            w++;
        end
        n_total++; if (w >= 200) $display("FAIL b2b_accept: timed out waiting for sym_ready"); else n_pass++;
        @(negedge clk);
        bus.sym_in = 3'b011;
        for (int i = 0; i < total_len; i++) begin
            logic ef, eo;
            ef = (i < FRAME_LEN) || (i >= f2);
            eo = (i < FRAME_LEN) ? ca[5 - i / BIT_CYCLES] :
                 (i >= f2)       ? cb[5 - (i - f2) / BIT_CYCLES] : IDLE_LVL;
            if (bus.tx_frame !== ef || bus.tx_out !== eo) errs++;
            if (bus.sym_ready !== (i == FRAME_LEN + GAP_CYCLES)) rdy_errs++;
            if (bus.code_stb === 1'b1) stb++;
            if (i == f2) bus.sym_valid = 1'b0;
            @(negedge clk);
        end
        n_total++; if (errs !== 0) $display("FAIL b2b_serial: got %0d bad cycles want 0", errs); else n_pass++;
        n_total++; if (rdy_errs !== 0) $display("FAIL b2b_ready_gap: got %0d bad ready cycles want 0", rdy_errs); else n_pass++;
        n_total++; if (stb !== 2) $display("FAIL b2b_code_stb: got %0d pulses want 2", stb); else n_pass++;
        n_total++; if (bus.code_out !== cb) $display("FAIL b2b_code_out: got %b want %b", bus.code_out, cb); else n_pass++;
        exp_code_out = cb;
    endtask

    task automatic test_illegal();
        bit ok;
        drive_sym(3'b100, ok);
        n_total++; if (!ok) $display("FAIL illegal_accept: timed out waiting for sym_ready"); else n_pass++;
        exp_err_cnt = sat_add(exp_err_cnt, 1);
        n_total++; if (bus.err !== 1'b1) $display("FAIL illegal_err: got %b want 1", bus.err); else n_pass++;
        n_total++; if (bus.err_cnt !== ERR_W'(exp_err_cnt)) $display("FAIL illegal_err_cnt: got %0d want %0d", bus.err_cnt, exp_err_cnt); else n_pass++;
        n_total++; if (bus.code_stb !== 1'b0 || bus.tx_frame !== 1'b0) $display("FAIL illegal_no_frame: got stb=%b frame=%b want 0 0", bus.code_stb, bus.tx_frame); else n_pass++;
        n_total++; if (bus.code_out !== exp_code_out) $display("FAIL illegal_code_out: got %b want %b", bus.code_out, exp_code_out); else n_pass++;
        n_total++; if (bus.sym_ready !== 1'b1) $display("FAIL illegal_ready: got %b want 1", bus.sym_ready); else n_pass++;
        drive_sym(3'b001, ok);
        n_total++; if (bus.err !== 1'b0 || bus.code_stb !== 1'b1) $display("FAIL illegal_next_accept: got err=%b stb=%b want 0 1", bus.err, bus.code_stb); else n_pass++;
        n_total++; if (bus.code_out !== ref_code[1]) $display("FAIL illegal_next_code: got %b want %b", bus.code_out, ref_code[1]); else n_pass++;
        exp_code_out = ref_code[1];
        capture_frame();
        n_total++; if (cap_timeout || cap_bits.size() !== FRAME_LEN || sample_errs(ref_code[1]) !== 0)
            $display("FAIL illegal_next_frame: got len=%0d bad=%0d timeout=%0d want len=%0d bad=0", cap_bits.size(), sample_errs(ref_code[1]), cap_timeout, FRAME_LEN);
        else n_pass++;
    endtask

    task automatic test_saturate();
        int w = 0, cnt_errs = 0, pulses = 0;
        int n = (1 << ERR_W) + 3;
        int unsigned base = exp_err_cnt;
        while (bus.sym_ready !== 1'b1 && w < 200) begin
            @(negedge clk);
            w++;
        end
        n_total++; if (w >= 200) $display("FAIL sat_wait: timed out waiting for sym_ready"); else n_pass++;
        bus.sym_in    = 3'b101;
        bus.sym_valid = 1'b1;
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            if (bus.err === 1'b1) pulses++;
            if (bus.err_cnt !== ERR_W'(sat_add(base, k))) cnt_errs++;
        end
        bus.sym_valid = 1'b0;
        exp_err_cnt = sat_add(base, n);
        n_total++; if (cnt_errs !== 0) $display("FAIL sat_track: got %0d bad counts want 0", cnt_errs); else n_pass++;
        n_total++; if (pulses !== n) $display("FAIL sat_pulses: got %0d want %0d", pulses, n); else n_pass++;
        @(negedge clk);
        n_total++; if (bus.err_cnt !== ERR_W'(ERR_MAX)) $display("FAIL sat_final: got %0d want %0d", bus.err_cnt, ERR_MAX); else n_pass++;
        n_total++; if (bus.err !== 1'b0 || bus.tx_frame !== 1'b0) $display("FAIL sat_quiet: got err=%b frame=%b want 0 0", bus.err, bus.tx_frame); else n_pass++;
    endtask

    task automatic test_reset_mid_frame();
        bit ok;
        int highs = 0;
        logic [5:0] c;
        c = ref_code[6];
        drive_sym(3'b110, ok);
        repeat (2 * BIT_CYCLES + 1) @(negedge clk);
        n_total++; if (bus.tx_frame !== 1'b1 || bus.tx_out !== c[3]) $display("FAIL rstmid_bit3: got frame=%b out=%b want 1 %b", bus.tx_frame, bus.tx_out, c[3]); else n_pass++;
        rst = 1'b1;
        @(negedge clk);
        n_total++; if (bus.tx_out !== IDLE_LVL || bus.tx_frame !== 1'b0) $display("FAIL rstmid_line: got out=%b frame=%b want %b 0", bus.tx_out, bus.tx_frame, IDLE_LVL); else n_pass++;
        n_total++; if (bus.sym_ready !== 1'b1) $display("FAIL rstmid_ready: got %b want 1", bus.sym_ready); else n_pass++;
        n_total++; if (bus.err_cnt !== ERR_W'(0) || bus.code_out !== 6'b0) $display("FAIL rstmid_regs: got err_cnt=%0d code=%b want 0 000000", bus.err_cnt, bus.code_out); else n_pass++;
        rst = 1'b0;
        exp_err_cnt  = 0;
        exp_code_out = '0;
        repeat (2 * FRAME_LEN) begin
            @(negedge clk);
            if (bus.tx_frame === 1'b1) highs++;
        end
        n_total++; if (highs !== 0) $display("FAIL rstmid_no_resume: got %0d frame cycles want 0", highs); else n_pass++;
    endtask

    task automatic test_loopback();
        logic [2:0] order [8];
        int recovered, want;
        bit ok;
        for (int round = 0; round < 3; round++) begin
            for (int i = 0; i < 8; i++) order[i] = 3'(i);
            for (int i = 7; i > 0; i--) begin
                int j = $urandom_range(i, 0);
                logic [2:0] t = order[i];
                order[i] = order[j];
                order[j] = t;
            end
            recovered = 0;
            want = 0;
            for (int i = 0; i < 8; i++) begin
                logic [2:0] s = order[i];
                repeat ($urandom_range(3, 0)) @(negedge clk);
                drive_sym(s, ok);
                if (ref_legal[s]) begin
                    logic [3:0] d;
                    want++;
                    exp_code_out = ref_code[s];
                    n_total++; if (!ok || bus.code_stb !== 1'b1 || bus.code_out !== ref_code[s])
                        $display("FAIL loop_accept sym=%b: got ok=%0d stb=%b code=%b want 1 1 %b", s, ok, bus.code_stb, bus.code_out, ref_code[s]);
                    else n_pass++;
                    capture_frame();
                    d = decode_word(word_from_samples());
                    n_total++; if (cap_timeout || cap_bits.size() !== FRAME_LEN || sample_errs(ref_code[s]) !== 0)
                        $display("FAIL loop_frame sym=%b: got len=%0d bad=%0d want len=%0d bad=0", s, cap_bits.size(), sample_errs(ref_code[s]), FRAME_LEN);
                    else n_pass++;
                    n_total++; if (d !== {1'b1, s}) $display("FAIL loop_decode: got found=%b sym=%b want 1 %b", d[3], d[2:0], s);
                    else begin n_pass++; recovered++; end
                end else begin
                    exp_err_cnt = sat_add(exp_err_cnt, 1);
                    n_total++; if (bus.err !== 1'b1 || bus.err_cnt !== ERR_W'(exp_err_cnt) || bus.tx_frame !== 1'b0 || bus.code_out !== exp_code_out)
                        $display("FAIL loop_illegal sym=%b: got err=%b cnt=%0d frame=%b code=%b want 1 %0d 0 %b", s, bus.err, bus.err_cnt, bus.tx_frame, bus.code_out, exp_err_cnt, exp_code_out);
                    else n_pass++;
                end
            end
            n_total++; if (recovered !== want) $display("FAIL loop_recovered: got %0d want %0d", recovered, want); else n_pass++;
        end
    endtask

    initial begin
        ref_code[0] = 6'b000000; ref_legal[0] = 1'b1;
        ref_code[1] = 6'b101111; ref_legal[1] = 1'b1;
        ref_code[2] = 6'b101100; ref_legal[2] = 1'b1;
        ref_code[3] = 6'b011011; ref_legal[3] = 1'b1;
        ref_code[4] = 6'b000000; ref_legal[4] = 1'b0;
        ref_code[5] = 6'b000000; ref_legal[5] = 1'b0;
        ref_code[6] = 6'b101101; ref_legal[6] = 1'b1;
        ref_code[7] = 6'b101010; ref_legal[7] = 1'b1;
        bus.sym_in    = 3'b000;
        bus.sym_valid = 1'b0;
        @(negedge clk);
        test_reset();
        test_single_111();
        test_back_to_back();
        test_illegal();
        test_saturate();
        test_reset_mid_frame();
        test_loopback();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
